// File: rtl/i2c_byte_master_if.sv
// Command/response handshake and open-drain line controls of the I2C byte master.
// The master modport is the engine side; the slave modport is the client driving commands.
interface i2c_byte_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_ack;
  logic       rsp_err;
  logic       bus_held;
  logic       scl_o;
  logic       sda_oe;
  logic       sda_i;

  modport master (
    input  cmd_valid, cmd_op, cmd_wdata, sda_i,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_ack, rsp_err, bus_held, scl_o, sda_oe
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_wdata, sda_i,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_ack, rsp_err, bus_held, scl_o, sda_oe
  );
endinterface

// File: rtl/i2c_byte_master.sv
// I2C byte-level master: runs one START/STOP/WRITE/READ command at a time, each bit split
// into four CLK_DIV-long quarter phases. SCL/SDA are open-drain controls (released = 1/0).
module i2c_byte_master #(
  parameter int CLK_DIV        = 100,
  parameter int I2C_DATA_WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  i2c_byte_master_if.master bus
);
  localparam int            CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [3:0]    ACK_BIT = 4'(I2C_DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, BIT, STOP, ERR} state_t;
  typedef enum logic [2:0] {
    OP_START = 3'd0, OP_STOP = 3'd1, OP_WRITE = 3'd2, OP_READ_ACK = 3'd3, OP_READ_NACK = 3'd4
  } op_t;

  state_t        state, nxt_state;
  op_t           op, nxt_op;
  logic [1:0]    qtr, nxt_qtr;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [3:0]    bit_cnt, nxt_bit;
  logic [6:0]    wsh, nxt_wsh;
  logic [7:0]    rsh, nxt_rsh;
  logic          ack_s, nxt_ack;
  logic          nxt_scl, nxt_sda, nxt_held;
  logic          nxt_rvalid, nxt_rack, nxt_rerr;
  logic [7:0]    nxt_rdata;
  logic          phase_end;
  logic          accept;

  assign bus.cmd_ready = (state == IDLE) && !bus.rsp_valid;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign phase_end     = (cnt == CNT_MAX);

  always_comb begin
    nxt_state  = state;
    nxt_op     = op;
    nxt_qtr    = qtr;
    nxt_cnt    = cnt;
    nxt_bit    = bit_cnt;
    nxt_wsh    = wsh;
    nxt_rsh    = rsh;
    nxt_ack    = ack_s;
    nxt_scl    = bus.scl_o;
    nxt_sda    = bus.sda_oe;
    nxt_held   = bus.bus_held;
    nxt_rvalid = 1'b0;
    nxt_rdata  = bus.rsp_rdata;
    nxt_rack   = bus.rsp_ack;
    nxt_rerr   = bus.rsp_err;

    if (state == START || state == BIT || state == STOP) begin
      nxt_cnt = phase_end ? '0 : cnt + 1'b1;
      if (phase_end) nxt_qtr = qtr + 2'd1;
    end

    case (state)
      IDLE: begin
        if (accept) begin
          nxt_cnt   = '0;
          nxt_qtr   = '0;
          nxt_bit   = '0;
          nxt_wsh   = bus.cmd_wdata[6:0];
          nxt_state = ERR;
          case (bus.cmd_op)
            OP_START: begin
              nxt_op    = OP_START;
              nxt_state = START;
              nxt_sda   = 1'b0;
            end
            OP_STOP: if (bus.bus_held) begin
              nxt_op    = OP_STOP;
              nxt_state = STOP;
              nxt_sda   = 1'b1;
            end
            OP_WRITE: if (bus.bus_held) begin
              nxt_op    = OP_WRITE;
              nxt_state = BIT;
              nxt_sda   = ~bus.cmd_wdata[7];
            end
            OP_READ_ACK, OP_READ_NACK: if (bus.bus_held) begin
              nxt_op    = (bus.cmd_op == OP_READ_ACK) ? OP_READ_ACK : OP_READ_NACK;
              nxt_state = BIT;
              nxt_sda   = 1'b0;
            end
            default: nxt_state = ERR;
          endcase
        end
      end
      ERR: begin
        nxt_state  = IDLE;
        nxt_rvalid = 1'b1;
        nxt_rerr   = 1'b1;
        nxt_rack   = 1'b0;
      end
      START: if (phase_end) begin
        case (qtr)
          2'd0: nxt_scl = 1'b1;
          2'd1: nxt_sda = 1'b1;
          2'd2: nxt_scl = 1'b0;
          default: begin
            nxt_state  = IDLE;
            nxt_held   = 1'b1;
            nxt_rvalid = 1'b1;
            nxt_rerr   = 1'b0;
            nxt_rack   = 1'b0;
          end
        endcase
      end
      BIT: if (phase_end) begin
        case (qtr)
          2'd0: ;
          2'd1: nxt_scl = 1'b1;
          2'd2: begin
            if (bit_cnt == ACK_BIT) nxt_ack = ~bus.sda_i;
            else                    nxt_rsh = {rsh[6:0], bus.sda_i};
          end
          default: begin
            nxt_scl = 1'b0;
            if (bit_cnt == ACK_BIT) begin
              nxt_state  = IDLE;
              nxt_rvalid = 1'b1;
              nxt_rerr   = 1'b0;
              nxt_rack   = (op == OP_WRITE) && ack_s;
              if (op != OP_WRITE) nxt_rdata = rsh;
            end else begin
              // SDA for the next bit changes on the same edge that pulls SCL low
              nxt_bit = bit_cnt + 4'd1;
              if (nxt_bit == ACK_BIT) begin
                nxt_sda = (op == OP_READ_ACK);
              end else if (op == OP_WRITE) begin
                nxt_sda = ~wsh[6];
                nxt_wsh = {wsh[5:0], 1'b0};
              end else begin
                nxt_sda = 1'b0;
              end
            end
          end
        endcase
      end
      STOP: if (phase_end) begin
        case (qtr)
          2'd0: nxt_scl = 1'b1;
          2'd1: ;
          2'd2: nxt_sda = 1'b0;
          default: begin
            nxt_state  = IDLE;
            nxt_held   = 1'b0;
            nxt_rvalid = 1'b1;
            nxt_rerr   = 1'b0;
            nxt_rack   = 1'b0;
          end
        endcase
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op            <= OP_START;
      qtr           <= '0;
      cnt           <= '0;
      bit_cnt       <= '0;
      wsh           <= '0;
      rsh           <= '0;
      ack_s         <= 1'b0;
      bus.scl_o     <= 1'b1;
      bus.sda_oe    <= 1'b0;
      bus.bus_held  <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_ack   <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else begin
      state         <= nxt_state;
      op            <= nxt_op;
      qtr           <= nxt_qtr;
      cnt           <= nxt_cnt;
      bit_cnt       <= nxt_bit;
      wsh           <= nxt_wsh;
      rsh           <= nxt_rsh;
      ack_s         <= nxt_ack;
      bus.scl_o     <= nxt_scl;
      bus.sda_oe    <= nxt_sda;
      bus.bus_held  <= nxt_held;
      bus.rsp_valid <= nxt_rvalid;
      bus.rsp_rdata <= nxt_rdata;
      bus.rsp_ack   <= nxt_rack;
      bus.rsp_err   <= nxt_rerr;
    end
  end
endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master with CLK_DIV=4 and a small behavioural I2C slave at
// address 0x22 that ACKs writes and returns 0x64, 0x65, ... on reads.
module tb_i2c_byte_master;
  localparam logic [7:0] RD0 = 8'h64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_byte_master_if bus();

  i2c_byte_master #(.CLK_DIV(4), .I2C_DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic s_drive = 1'b0;
  logic sda_line;
  assign sda_line  = ~(bus.sda_oe | s_drive);
  assign bus.sda_i = sda_line;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: mode 0 idle, 1 address, 2 write data, 3 read data
  int         s_mode = 0;
  int         s_bit = 0;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  logic [7:0] s_shift = '0;
  logic [7:0] s_addr = '0;
  logic [7:0] s_rd = '0;
  logic [7:0] rd_next;
  logic       s_match = 1'b0;
  logic       s_mack = 1'b0;
  logic       s_rise = 1'b0;
  logic       s_en = 1'b1;
  logic       pscl = 1'b1;
  logic       psda = 1'b1;
  assign rd_next = s_rd + 8'd1;

  always @(negedge clk) begin
    if (!rst_n) begin
      s_mode <= 0; s_bit <= 0; s_drive <= 1'b0; s_rise <= 1'b0;
      pscl <= 1'b1; psda <= 1'b1;
    end else begin
      pscl <= bus.scl_o;
      psda <= sda_line;
      if (bus.scl_o && pscl && psda && !sda_line) begin
        start_cnt <= start_cnt + 1;
        s_mode <= 1; s_bit <= 0; s_shift <= '0; s_rise <= 1'b0; s_drive <= 1'b0;
      end else if (bus.scl_o && pscl && !psda && sda_line) begin
        stop_cnt <= stop_cnt + 1;
        s_mode <= 0; s_rise <= 1'b0; s_drive <= 1'b0;
      end else if (bus.scl_o && !pscl) begin
        s_rise <= 1'b1;
        if (s_mode != 0) begin
          if (s_bit < 8) begin
            if (s_mode != 3) s_shift <= {s_shift[6:0], sda_line};
          end else if (s_mode == 3) begin
            s_mack <= ~sda_line;
          end
        end
      end else if (!bus.scl_o && pscl && s_rise) begin
        s_rise <= 1'b0;
        if (s_mode == 1 || s_mode == 2) begin
          if (s_bit == 7) begin
            s_bit <= 8;
            if (s_mode == 1) begin
              s_addr  <= s_shift;
              s_match <= s_en && (s_shift[7:1] == 7'h22);
              s_drive <= s_en && (s_shift[7:1] == 7'h22);
            end else begin
              s_drive <= 1'b1;
            end
          end else if (s_bit == 8) begin
            s_bit <= 0;
            s_drive <= 1'b0;
            if (s_mode == 1) begin
              if (s_match && s_addr[0]) begin
                s_mode <= 3; s_rd <= RD0; s_drive <= ~RD0[7];
              end else if (s_match) begin
                s_mode <= 2;
              end else begin
                s_mode <= 0;
              end
            end
          end else begin
            s_bit <= s_bit + 1;
          end
        end else if (s_mode == 3) begin
          if (s_bit < 7) begin
            s_bit <= s_bit + 1; s_drive <= ~s_rd[6 - s_bit];
          end else if (s_bit == 7) begin
            s_bit <= 8; s_drive <= 1'b0;
          end else begin
            s_bit <= 0;
            if (s_mack) begin
              s_rd <= rd_next; s_drive <= ~rd_next[7];
            end else begin
              s_mode <= 0; s_drive <= 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic do_cmd(input logic [2:0] op, input logic [7:0] wd, output int lat);
    int n;
    @(negedge clk);
    bus.cmd_op = op; bus.cmd_wdata = wd; bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 400) begin @(negedge clk); n++; end
    check("accept_ready", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("busy_ready_low", bus.cmd_ready, 1'b0);
    lat = 0;
    while (lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (bus.rsp_valid) break;
    end
    @(posedge clk); #1;
    check("rsp_one_cycle", bus.rsp_valid, 1'b0);
    check("ready_restored", bus.cmd_ready, 1'b1);
  endtask

  initial begin
    int lat;
    int seen;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_wdata = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_ctrl", {bus.scl_o, bus.sda_oe, bus.cmd_ready, bus.rsp_valid,
                       bus.rsp_ack, bus.rsp_err, bus.bus_held}, 7'b1010000);
    check("rst_rdata", bus.rsp_rdata, 8'h00);
    rst_n = 1'b1;

    // Bus-not-held write is rejected with no line activity
    do_cmd(3'd2, 8'h10, lat);
    check("err_wr_lat", lat, 1);
    check("err_wr_flags", {bus.rsp_err, bus.rsp_ack}, 2'b10);
    check("err_wr_rdata", bus.rsp_rdata, 8'h00);
    check("err_wr_lines", {bus.scl_o, bus.sda_oe, bus.bus_held}, 3'b100);
    check("err_wr_nostart", start_cnt, 0);

    // START + WRITE 0x44 with ACK
    do_cmd(3'd0, 8'h00, lat);
    check("t1_start_lat", lat, 16);
    check("t1_start_state", {bus.bus_held, bus.scl_o, bus.sda_oe, bus.rsp_err}, 4'b1010);
    check("t1_start_seen", start_cnt, 1);
    do_cmd(3'd2, 8'h44, lat);
    check("t1_wr_lat", lat, 144);
    check("t1_wr_ack", {bus.rsp_ack, bus.rsp_err}, 2'b10);
    check("t1_slave_byte", s_addr, 8'h44);
    check("t1_rw_bit", s_addr[0], 1'b0);
    check("t1_after_lines", {bus.scl_o, bus.sda_oe}, 2'b00);
    do_cmd(3'd1, 8'h00, lat);
    check("t1_stop_lat", lat, 16);
    check("t1_stop_seen", stop_cnt, 1);

    // START + WRITE 0x45 + READ_NACK + STOP
    do_cmd(3'd0, 8'h00, lat);
    do_cmd(3'd2, 8'h45, lat);
    check("t2_wr_ack", bus.rsp_ack, 1'b1);
    do_cmd(3'd4, 8'h00, lat);
    check("t2_rd_lat", lat, 144);
    check("t2_rd_data", bus.rsp_rdata, 8'h64);
    check("t2_rd_ack", {bus.rsp_ack, bus.rsp_err}, 2'b00);
    check("t2_master_nack", s_mack, 1'b0);
    do_cmd(3'd1, 8'h00, lat);
    check("t2_stop_seen", stop_cnt, 2);
    check("t2_idle_lines", {bus.bus_held, bus.scl_o, bus.sda_oe}, 3'b010);

    // Illegal op and idle STOP
    do_cmd(3'd6, 8'hff, lat);
    check("err_op6_lat", lat, 1);
    check("err_op6_flags", {bus.rsp_err, bus.rsp_ack, bus.scl_o}, 3'b101);
    check("err_op6_rdata", bus.rsp_rdata, 8'h64);
    do_cmd(3'd1, 8'h00, lat);
    check("err_stop_lat", lat, 1);
    check("err_stop_flags", {bus.rsp_err, bus.bus_held, bus.scl_o}, 3'b101);

    // Two reads: ACK then NACK
    do_cmd(3'd0, 8'h00, lat);
    do_cmd(3'd2, 8'h45, lat);
    do_cmd(3'd3, 8'h00, lat);
    check("t3_rd1_data", bus.rsp_rdata, 8'h64);
    check("t3_master_ack", s_mack, 1'b1);
    do_cmd(3'd4, 8'h00, lat);
    check("t3_rd2_data", bus.rsp_rdata, 8'h65);
    check("t3_master_nack", s_mack, 1'b0);
    do_cmd(3'd1, 8'h00, lat);
    check("t3_counts", {start_cnt[7:0], stop_cnt[7:0]}, 16'h0303);

    // No slave present: NACK, then STOP still accepted
    s_en = 1'b0;
    do_cmd(3'd0, 8'h00, lat);
    do_cmd(3'd2, 8'h44, lat);
    check("t4_wr_lat", lat, 144);
    check("t4_nack", {bus.rsp_ack, bus.rsp_err}, 2'b00);
    do_cmd(3'd1, 8'h00, lat);
    check("t4_stop", {lat[7:0], bus.rsp_err, bus.bus_held}, {8'd16, 2'b00});
    s_en = 1'b1;

    // Repeated START, then reset in the middle of the next byte
    do_cmd(3'd0, 8'h00, lat);
    do_cmd(3'd2, 8'h44, lat);
    do_cmd(3'd0, 8'h00, lat);
    check("t6_rstart_lat", lat, 16);
    check("t6_rstart_seen", start_cnt, 6);
    check("t6_rstart_held", {bus.bus_held, bus.rsp_err}, 2'b10);
    @(negedge clk);
    bus.cmd_op = 3'd2; bus.cmd_wdata = 8'h45; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (65) @(posedge clk);
    #1;
    check("t6_pre_rst_lines", {bus.scl_o, bus.sda_oe}, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_lines", {bus.scl_o, bus.sda_oe}, 2'b10);
    check("t6_async_ctrl", {bus.bus_held, bus.cmd_ready, bus.rsp_valid}, 3'b010);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen++;
    end
    check("t6_no_rsp", seen, 0);
    do_cmd(3'd0, 8'h00, lat);
    check("t6_start_lat", lat, 16);
    check("t6_start_held", bus.bus_held, 1'b1);
    check("t6_start_seen", start_cnt, 7);
    do_cmd(3'd1, 8'h00, lat);
    check("t6_stop", {lat[7:0], bus.bus_held, bus.scl_o, bus.sda_oe}, {8'd16, 3'b010});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
